// File: rtl/bsg_link_pkg.sv
// Definitions shared by the upstream and downstream link channels:
// FSM state encoding, default credit sizing and beat order.
package bsg_link_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND_LO,
      SEND_HI
   } link_state_e;

   localparam int unsigned LINK_CREDITS     = 64;
   localparam int unsigned LINK_TOKEN_DECIM = 3;

   // Core words go out least-significant beat first.
   localparam bit LINK_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bsg_link_token_sync.sv
// Brings the asynchronous token line into the clk domain and emits a
// one-cycle ret pulse for every toggle (either edge).
module bsg_link_token_sync (
   input  logic clk,
   input  logic rst,
   input  logic io_token_i,
   output logic ret_o
);

   logic sync1_q, sync2_q, last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         sync1_q <= io_token_i;
         sync2_q <= sync1_q;
         last_q  <= sync2_q;
      end
   end

   assign ret_o = sync2_q ^ last_q;

endmodule

// File: rtl/bsg_link_upstream_ch.sv
// Transmit channel: splits each core word into two io beats and meters
// traffic against credits returned by the downstream channel's token line.
module bsg_link_upstream_ch
   import bsg_link_pkg::*;
#(
   parameter int unsigned CORE_W      = 16,
   parameter int unsigned IO_W        = 8,
   parameter int unsigned CREDITS     = LINK_CREDITS,
   parameter int unsigned TOKEN_DECIM = LINK_TOKEN_DECIM,
   parameter int unsigned CW          = $clog2(CREDITS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CORE_W-1:0] core_data_i,
   input  logic              core_valid_i,
   output logic              core_ready_o,
   output logic [IO_W-1:0]   io_data_o,
   output logic              io_valid_o,
   input  logic              io_token_i,
   output logic [CW-1:0]     credit_cnt_o,
   output logic              credit_stall_o,
   output logic              credit_ovf_o
);

   localparam logic [CW:0] TOKEN_INC = (CW + 1)'(1) << TOKEN_DECIM;
   localparam logic [CW:0] CREDITS_W = (CW + 1)'(CREDITS);

   link_state_e       state_q, state_d;
   logic [CORE_W-1:0] hold_q, hold_d;
   logic [IO_W-1:0]   io_data_q, io_data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              ret;
   logic              accept;
   logic [CW:0]       cnt_sum;
   logic [IO_W-1:0]   first_beat, second_beat;

   bsg_link_token_sync u_token_sync (
      .clk        (clk),
      .rst        (rst),
      .io_token_i (io_token_i),
      .ret_o      (ret)
   );

   assign first_beat  = LINK_LSB_FIRST ? core_data_i[IO_W-1:0] : core_data_i[CORE_W-1:IO_W];
   assign second_beat = LINK_LSB_FIRST ? hold_q[CORE_W-1:IO_W]  : hold_q[IO_W-1:0];

   // A new word may be taken while the high beat of the previous one is
   // on the wire, which gives back-to-back words with no idle cycle.
   assign core_ready_o = ((state_q == IDLE) || (state_q == SEND_HI)) && (cnt_q != '0);
   assign accept       = core_valid_i && core_ready_o;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      io_data_d = '0;
      if (accept) begin
         state_d   = SEND_LO;
         hold_d    = core_data_i;
         io_data_d = first_beat;
      end else begin
         case (state_q)
            SEND_LO: begin
               state_d   = SEND_HI;
               io_data_d = second_beat;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_sum = {1'b0, cnt_q} - (CW + 1)'(accept) + (ret ? TOKEN_INC : '0);
      cnt_d   = cnt_sum[CW-1:0];
      ovf_d   = ovf_q;
      if (cnt_sum > CREDITS_W) begin
         cnt_d = CW'(CREDITS);
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         io_data_q <= '0;
         cnt_q     <= CW'(CREDITS);
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         io_data_q <= io_data_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign io_data_o      = io_data_q;
   assign io_valid_o     = (state_q != IDLE);
   assign credit_cnt_o   = cnt_q;
   assign credit_stall_o = (cnt_q == '0);
   assign credit_ovf_o   = ovf_q;

endmodule

// File: tb/tb_bsg_link_upstream_ch.sv
// Self-checking bench for bsg_link_upstream_ch: directed vector table,
// hand-written credit sequences, and randomized traffic against a beat-queue model.
module tb_bsg_link_upstream_ch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] core_data_i = '0;
   logic        core_valid_i = 1'b0;
   logic        core_ready_o;
   logic [7:0]  io_data_o;
   logic        io_valid_o;
   logic        io_token_i = 1'b0;
   logic [6:0]  credit_cnt_o;
   logic        credit_stall_o;
   logic        credit_ovf_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   bsg_link_upstream_ch #(
      .CORE_W      (16),
      .IO_W        (8),
      .CREDITS     (64),
      .TOKEN_DECIM (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .core_data_i    (core_data_i),
      .core_valid_i   (core_valid_i),
      .core_ready_o   (core_ready_o),
      .io_data_o      (io_data_o),
      .io_valid_o     (io_valid_o),
      .io_token_i     (io_token_i),
      .credit_cnt_o   (credit_cnt_o),
      .credit_stall_o (credit_stall_o),
      .credit_ovf_o   (credit_ovf_o)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model: beats waiting to appear on the wire (front = beat
   // currently shown), credit arithmetic, and the last three sampled tokens.
   logic [7:0] mq[$];
   int         m_cred;
   bit         m_ovf;
   bit         m_hist[$];

   function automatic logic [18:0] model_out();
      logic       vld;
      logic [7:0] dat;
      logic       rdy;
      vld = (mq.size() != 0);
      dat = vld ? mq[0] : 8'h00;
      rdy = (mq.size() <= 1) && (m_cred != 0);
      return {vld, dat, rdy, 7'(m_cred), (m_cred == 0), m_ovf};
   endfunction

   task automatic model_step(input bit r, input bit v, input logic [15:0] d, input bit tok);
      bit acc;
      bit ret;
      if (r) begin
         mq.delete();
         m_cred = 64;
         m_ovf  = 1'b0;
         m_hist = '{1'b0, 1'b0, 1'b0};
      end else begin
         acc = v && (mq.size() <= 1) && (m_cred != 0);
         // A toggle sampled at edge k is credited at edge k+2.
         ret = m_hist[1] ^ m_hist[0];
         if (mq.size() != 0) void'(mq.pop_front());
         if (acc) begin
            mq.push_back(d[7:0]);
            mq.push_back(d[15:8]);
         end
         m_cred = m_cred - (acc ? 1 : 0) + (ret ? 8 : 0);
         if (m_cred > 64) begin
            m_cred = 64;
            m_ovf  = 1'b1;
         end
         void'(m_hist.pop_front());
         m_hist.push_back(tok);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        v;
      logic [15:0] d;
      logic        tok;
      logic        vld;
      logic [7:0]  dat;
      logic        rdy;
      logic [6:0]  cnt;
      logic        ovf;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int unsigned accepted;
      int unsigned badr, badv, badd, n, g, tok_pct;
      logic [7:0]  eq[$];
      logic [7:0]  exp_b;
      bit          r, v, tk;
      logic [15:0] d;

      vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 1'b0, 7'd63, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hBE, 1'b1, 7'd63, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'd63, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 7'd63, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 7'd63, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 7'd63, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h34, 1'b0, 7'd63, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h12, 1'b1, 7'd63, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'd64, 1'b0};

      rst = 1'b1;
      @(posedge clk);
      next_cycle();

      // Directed table: reset values, single word, overflow, reset mid-word.
      for (int i = 0; i < 16; i++) begin
         rst          = vecs[i].rst;
         core_valid_i = vecs[i].v;
         core_data_i  = vecs[i].d;
         io_token_i   = vecs[i].tok;
         @(negedge clk);
         check($sformatf("vec%0d.valid", i), 32'(io_valid_o), 32'(vecs[i].vld));
         check($sformatf("vec%0d.data", i), 32'(io_data_o), 32'(vecs[i].dat));
         check($sformatf("vec%0d.ready", i), 32'(core_ready_o), 32'(vecs[i].rdy));
         check($sformatf("vec%0d.credits", i), 32'(credit_cnt_o), 32'(vecs[i].cnt));
         check($sformatf("vec%0d.stall", i), 32'(credit_stall_o), 32'(vecs[i].cnt == 7'd0));
         check($sformatf("vec%0d.ovf", i), 32'(credit_ovf_o), 32'(vecs[i].ovf));
         next_cycle();
      end
      rst = 1'b0;

      // 64 back-to-back words with no tokens: drains every credit.
      accepted = 0; badr = 0; badv = 0; badd = 0;
      core_valid_i = 1'b1;
      core_data_i  = 16'($urandom);
      for (int t = 0; t < 132; t++) begin
         @(negedge clk);
         if (core_ready_o !== ((t % 2 == 0) && (t <= 126))) badr++;
         if (io_valid_o !== ((t >= 1) && (t <= 128))) badv++;
         if (io_valid_o === 1'b1) begin
            if (eq.size() == 0) badd++;
            else begin
               exp_b = eq.pop_front();
               if (io_data_o !== exp_b) badd++;
            end
         end
         if (core_ready_o === 1'b1) begin
            accepted++;
            eq.push_back(core_data_i[7:0]);
            eq.push_back(core_data_i[15:8]);
         end
         next_cycle();
         if (core_ready_o === 1'b0 || t % 2 == 0) core_data_i = 16'($urandom);
      end
      core_valid_i = 1'b0;
      @(negedge clk);
      check("burst.ready_pattern_errors", badr, 0);
      check("burst.valid_pattern_errors", badv, 0);
      check("burst.data_errors", badd, 0);
      check("burst.accepted", accepted, 64);
      check("burst.credits", 32'(credit_cnt_o), 0);
      check("burst.stall", 32'(credit_stall_o), 1);
      check("burst.ready", 32'(core_ready_o), 0);

      // Single toggle from zero credits.
      next_cycle();
      io_token_i = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("tok0.credits_before", 32'(credit_cnt_o), 0);
      check("tok0.ready_before", 32'(core_ready_o), 0);
      next_cycle();
      @(negedge clk);
      check("tok0.credits_after", 32'(credit_cnt_o), 8);
      check("tok0.ready_after", 32'(core_ready_o), 1);
      check("tok0.stall_after", 32'(credit_stall_o), 0);

      // Bring credits to 10, then accept on the same edge a token returns.
      next_cycle();
      io_token_i = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("coinc.credits16", 32'(credit_cnt_o), 16);
      n = 0; g = 0;
      while (n < 6 && g < 40) begin
         next_cycle();
         core_valid_i = 1'b1;
         core_data_i  = 16'($urandom);
         @(negedge clk);
         if (core_ready_o === 1'b1) n++;
         g++;
      end
      check("coinc.accepted6", n, 6);
      next_cycle();
      core_valid_i = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("coinc.credits10", 32'(credit_cnt_o), 10);
      next_cycle();
      io_token_i = 1'b1;
      next_cycle();
      next_cycle();
      core_valid_i = 1'b1;
      core_data_i  = 16'hA55A;
      @(negedge clk);
      check("coinc.ready", 32'(core_ready_o), 1);
      check("coinc.credits_pre", 32'(credit_cnt_o), 10);
      next_cycle();
      core_valid_i = 1'b0;
      @(negedge clk);
      check("coinc.credits17", 32'(credit_cnt_o), 17);

      // Randomized traffic against the model.
      next_cycle();
      rst = 1'b1;
      core_valid_i = 1'b0;
      @(negedge clk);
      model_step(1'b1, 1'b0, 16'h0, io_token_i);
      next_cycle();
      for (int blk = 0; blk < 3; blk++) begin
         tok_pct = (blk == 0) ? 3 : (blk == 1) ? 9 : 25;
         for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(99) < 1);
            v  = ($urandom_range(99) < 70);
            d  = 16'($urandom);
            tk = ($urandom_range(99) < tok_pct) ? ~io_token_i : io_token_i;
            rst          = r;
            core_valid_i = v;
            core_data_i  = d;
            io_token_i   = tk;
            @(negedge clk);
            check($sformatf("rand%0d_%0d {vld,dat,rdy,cnt,stall,ovf}", blk, i),
                  32'({io_valid_o, io_data_o, core_ready_o, credit_cnt_o,
                       credit_stall_o, credit_ovf_o}),
                  32'(model_out()));
            model_step(r, v, d, tk);
            next_cycle();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_link_upstream_ch.md
Name: bsg_link_upstream_ch

Overview:
- Transmit-side channel of the off-chip link; it is the stage directly upstream of the downstream receive channel.
- Accepts 16-bit core words and serializes each into two 8-bit io beats (low byte first) with a qualifying valid.
- Meters traffic with a credit counter sized to the downstream 64-entry buffer.
- Restores credits from the toggling token line returned by the downstream channel.

Parameters:
- CORE_W, 16, core word width; must equal 2*IO_W.
- IO_W, 8, io beat width.
- CREDITS, 64, downstream buffer depth in core words; initial and maximum credit count.
- TOKEN_DECIM, 3, log2 of credits returned per token toggle (one toggle = 8 credits).
- CW, $clog2(CREDITS+1), credit counter width (7).

Ports:
- clk  in  1  io-side clock.
- rst  in  1  synchronous, active-high reset.
- core_data_i  in  CORE_W  word to send.
- core_valid_i  in  1  word offered.
- core_ready_o  out  1  word accepted when core_valid_i && core_ready_o.
- io_data_o  out  IO_W  serialized beat.
- io_valid_o  out  1  io_data_o qualifier.
- io_token_i  in  1  token toggle from the downstream channel (asynchronous to clk).
- credit_cnt_o  out  CW  current credits.
- credit_stall_o  out  1  credit_cnt_o==0.
- credit_ovf_o  out  1  sticky: a token return would exceed CREDITS.

Behaviour:
- Reset: clk and rst are as decided — reset rst, synchronous, active-high; clock clk.
- On the first clk edge with rst=1:
  - state=IDLE; hold register=0; io_data_o=0; io_valid_o=0.
  - credit_cnt_o=CREDITS; credit_stall_o=0; credit_ovf_o=0; synchronizer flops=0.
- Reset mid-word: any partially sent word is discarded, and io_valid_o=0 from the cycle after rst is sampled. The credit spent on the discarded word is not refunded; the counter reloads to CREDITS.
- FSM states:
  - IDLE: no beat driven.
  - SEND_LO: drive hold[7:0].
  - SEND_HI: drive hold[15:8].
  - io_valid_o=1 exactly in SEND_LO and SEND_HI. io_data_o is registered and is 0 in IDLE.
- core_ready_o (combinational) = (state==IDLE || state==SEND_HI) && credit_cnt_o!=0.
- On accept:
  - hold<=core_data_i; state<=SEND_LO; credits decrement by 1.
  - Latency: accepted at edge N, low byte visible in cycle N+1, high byte in cycle N+2.
- Transitions:
  - SEND_LO -> SEND_HI unconditionally.
  - SEND_HI -> SEND_LO on accept, else IDLE.
  - Sustained throughput is one word per 2 cycles with no bubble.
- Token path:
  - io_token_i passes through a 2-flop synchronizer, then a third flop for edge detection.
  - Each edge (rise or fall) pulses ret for one cycle.
  - Latency: 3 clk edges from toggle to credit update.
- Credit update each cycle: next = cnt − accept + (ret ? 2^TOKEN_DECIM : 0).
  - Simultaneous accept and return apply both in the same cycle.
  - If next > CREDITS: clamp to CREDITS and set credit_ovf_o. It stays set until rst.
- credit_cnt_o never underflows: an accept requires cnt!=0.
- core_valid_i with core_ready_o=0 is ignored; the upstream must hold the data.

Decomposition:
- Shared package bsg_link_pkg:
  - FSM state enum {IDLE, SEND_LO, SEND_HI}.
  - Default CREDITS / TOKEN_DECIM constants, shared with the downstream channel.
  - Byte-order constant (LSB first).
- One sub-module, bsg_link_token_sync: 2-flop synchronizer plus edge detector, producing the single-cycle ret pulse.

Test Plan:
- Reset: hold rst 2 cycles, release -> credit_cnt_o=64, core_ready_o=1, io_valid_o=0, credit_ovf_o=0.
- Single word 0xBEEF accepted at edge N -> io_data_o=0xEF (valid) in cycle N+1, 0xBE in N+2, io_valid_o=0 in N+3; credit_cnt_o=63.
- 64 back-to-back words, no tokens -> io_valid_o continuously high for 128 cycles; core_ready_o=0 after 64th accept; credit_cnt_o=0, credit_stall_o=1.
- From credits=0, toggle io_token_i once -> credit_cnt_o=8 three edges later; core_ready_o reasserts the same cycle.
- Credits=10, accept coincident with a ret pulse -> credit_cnt_o=17 next cycle.
- Credits=64, toggle token -> credit_cnt_o stays 64, credit_ovf_o=1 sticky.
- Reset mid-word (cycle after low byte): at the next edge io_valid_o=0, credits=64, credit_ovf_o=0.
